// File: rtl/rn_pkg.sv
// Shared rename/ROB types: physical register handles, renamed instructions,
// branch results and writeback completions.
package rn_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic   valid;
    logic   is_branch;
    p_reg_t rd;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
  } rob_wb_t;

  // Physical register 0 is hardwired, so it is never retired or released.
  function automatic logic has_dest(input p_reg_t rd);
    return rd.valid & (rd.idx != {PREG_W{1'b0}});
  endfunction

endpackage

// File: rtl/rob_commit.sv
// In-order completion tracker: allocates tags at dispatch, collects writebacks,
// retires in order and walks back younger entries after a branch mispredict.
module rob_commit
  import rn_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  rinstr_t          rinstr_i,
  output logic             rob_full_o,
  output logic [TAG_W-1:0] rob_tag_o,
  input  rob_wb_t          wb_i,
  input  br_result_t       br_result_i,
  output p_reg_t           p_commit_o,
  output logic             empty_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   head_q, tail_q, walk_q, br_tag_q;
  logic [TAG_W:0]     count_q, count_d;
  logic               br_pending_q;
  logic [DEPTH-1:0]   valid_q, done_q, has_rd_q;
  logic [PREG_W-1:0]  pidx_q [DEPTH];
  logic               rob_full_q, empty_q;
  p_reg_t             p_commit_q;

  logic               do_alloc, mispredict, alloc_ok, do_commit, do_flush, flush_last, no_younger;

  // Per-cycle control decisions and next count/state.
  always_comb begin
    do_alloc   = rinstr_i.valid & ~rob_full_q;
    mispredict = br_result_i.valid & ~br_result_i.hit & br_pending_q;
    alloc_ok   = do_alloc & ~mispredict;
    do_commit  = (state_q == RUN) & valid_q[head_q] & done_q[head_q];
    do_flush   = (state_q == FLUSH);
    flush_last = (walk_q == br_tag_q + TAG_W'(1));
    no_younger = (tail_q == br_tag_q + TAG_W'(1));
    count_d    = count_q + (TAG_W+1)'(alloc_ok) - (TAG_W+1)'(do_commit | do_flush);
    state_d    = state_q;
    case (state_q)
      RUN:     state_d = (mispredict & ~no_younger) ? FLUSH : RUN;
      FLUSH:   state_d = flush_last ? RUN : FLUSH;
      default: state_d = RUN;
    endcase
  end

  // Entry array, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      walk_q       <= '0;
      br_tag_q     <= '0;
      count_q      <= '0;
      br_pending_q <= 1'b0;
      valid_q      <= '0;
      done_q       <= '0;
      has_rd_q     <= '0;
      for (int i = 0; i < DEPTH; i++) pidx_q[i] <= '0;
      rob_full_q   <= 1'b0;
      empty_q      <= 1'b1;
      p_commit_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rob_full_q <= (count_d == (TAG_W+1)'(DEPTH)) | (state_d == FLUSH);
      empty_q    <= (count_d == '0);
      p_commit_q <= '0;

      // Squash wins over a writeback to the entry being walked this cycle.
      if (wb_i.valid && valid_q[wb_i.tag] && !(do_flush && (wb_i.tag == walk_q)))
        done_q[wb_i.tag] <= 1'b1;

      if (br_result_i.valid) br_pending_q <= 1'b0;

      if (alloc_ok) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        has_rd_q[tail_q] <= has_dest(rinstr_i.rd);
        pidx_q[tail_q]   <= rinstr_i.rd.idx;
        tail_q           <= tail_q + TAG_W'(1);
        if (rinstr_i.is_branch) begin
          br_tag_q     <= tail_q;
          br_pending_q <= 1'b1;
        end
      end

      if (mispredict && !no_younger) walk_q <= tail_q - TAG_W'(1);

      if (do_commit) begin
        valid_q[head_q]  <= 1'b0;
        head_q           <= head_q + TAG_W'(1);
        p_commit_q.valid <= has_rd_q[head_q];
        p_commit_q.idx   <= has_rd_q[head_q] ? pidx_q[head_q] : {PREG_W{1'b0}};
      end

      if (do_flush) begin
        valid_q[walk_q]  <= 1'b0;
        p_commit_q.valid <= has_rd_q[walk_q];
        p_commit_q.idx   <= has_rd_q[walk_q] ? pidx_q[walk_q] : {PREG_W{1'b0}};
        if (flush_last) tail_q <= br_tag_q + TAG_W'(1);
        else            walk_q <= walk_q - TAG_W'(1);
      end
    end
  end

  assign rob_full_o = rob_full_q;
  assign empty_o    = empty_q;
  assign p_commit_o = p_commit_q;
  assign rob_tag_o  = tail_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit with hand-computed expectations.
module tb_rob_commit;
  import rn_pkg::*;

  logic       clk;
  logic       rst_ni;
  rinstr_t    rinstr_i;
  logic       rob_full_o;
  logic [3:0] rob_tag_o;
  rob_wb_t    wb_i;
  br_result_t br_result_i;
  p_reg_t     p_commit_o;
  logic       empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  rob_commit dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .rinstr_i    (rinstr_i),
    .rob_full_o  (rob_full_o),
    .rob_tag_o   (rob_tag_o),
    .wb_i        (wb_i),
    .br_result_i (br_result_i),
    .p_commit_o  (p_commit_o),
    .empty_o     (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc(input logic v, input int idx);
    logic [5:0] i6;
    i6 = 6'(idx);
    return {25'd0, v, i6};
  endfunction

  function automatic logic [31:0] pc_obs();
    return {25'd0, p_commit_o.valid, p_commit_o.idx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rinstr_i = '0; wb_i = '0; br_result_i = '0;
    step(); step();
    rst_ni = 1'b1;
  endtask

  task automatic disp(input logic br, input logic rv, input int idx);
    rinstr_i.valid = 1'b1;
    rinstr_i.is_branch = br;
    rinstr_i.rd.valid = rv;
    rinstr_i.rd.idx = 6'(idx);
    step();
    rinstr_i = '0;
  endtask

  task automatic wb(input int tag);
    wb_i.valid = 1'b1;
    wb_i.tag = 4'(tag);
    step();
    wb_i = '0;
  endtask

  task automatic br_res(input logic hit);
    br_result_i.valid = 1'b1;
    br_result_i.hit = hit;
    step();
    br_result_i = '0;
  endtask

  // Tags 0..2 normal (pregs 10..12), 3 branch, 4:50, 5:no rd, 6:52
  task automatic disp_branch_set();
    disp(1'b0, 1'b1, 10);
    disp(1'b0, 1'b1, 11);
    disp(1'b0, 1'b1, 12);
    disp(1'b1, 1'b0, 0);
    disp(1'b0, 1'b1, 50);
    disp(1'b0, 1'b0, 51);
    disp(1'b0, 1'b1, 52);
  endtask

  logic       hit_v [7];
  int         hit_i [7];

  initial begin
    rinstr_i = '0; wb_i = '0; br_result_i = '0; rst_ni = 1'b1;
    hit_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    hit_i = '{10, 11, 12, 0, 50, 0, 52};

    // Reset state
    do_reset();
    check_val("rst_empty", 32'(empty_o), 32'd1);
    check_val("rst_full", 32'(rob_full_o), 32'd0);
    check_val("rst_pcommit", pc_obs(), pc(1'b0, 0));
    check_val("rst_tag", 32'(rob_tag_o), 32'd0);

    // Fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      check_val("fill_tag", 32'(rob_tag_o), 32'(i));
      disp(1'b0, 1'b1, i + 1);
    end
    check_val("fill_full", 32'(rob_full_o), 32'd1);
    check_val("fill_empty", 32'(empty_o), 32'd0);
    rinstr_i.valid = 1'b1; rinstr_i.rd.valid = 1'b1; rinstr_i.rd.idx = 6'd17;
    step(); step();
    check_val("held_tag", 32'(rob_tag_o), 32'd0);
    check_val("held_full", 32'(rob_full_o), 32'd1);
    wb_i.valid = 1'b1; wb_i.tag = 4'd0;
    step();
    wb_i = '0;
    check_val("held_full_wb", 32'(rob_full_o), 32'd1);
    step();
    check_val("first_commit", pc_obs(), pc(1'b1, 1));
    check_val("no_alloc_in_full", 32'(rob_tag_o), 32'd0);
    check_val("full_drop", 32'(rob_full_o), 32'd0);
    step();
    rinstr_i = '0;
    check_val("alloc17_tag", 32'(rob_tag_o), 32'd1);
    check_val("alloc17_full", 32'(rob_full_o), 32'd1);
    for (int j = 1; j < 16; j++) begin
      wb(j);
      if (j >= 2) check_val("drain_pc", pc_obs(), pc(1'b1, j));
    end
    wb(0);
    check_val("drain_pc16", pc_obs(), pc(1'b1, 16));
    step();
    check_val("drain_pc17", pc_obs(), pc(1'b1, 17));
    check_val("drain_empty", 32'(empty_o), 32'd1);

    // Out-of-order writeback
    do_reset();
    disp(1'b0, 1'b1, 40);
    disp(1'b0, 1'b1, 41);
    disp(1'b0, 1'b1, 42);
    wb(2);
    wb(0);
    check_val("ooo_nopulse", pc_obs(), pc(1'b0, 0));
    wb(1);
    check_val("ooo_pc40", pc_obs(), pc(1'b1, 40));
    step();
    check_val("ooo_pc41", pc_obs(), pc(1'b1, 41));
    step();
    check_val("ooo_pc42", pc_obs(), pc(1'b1, 42));
    step();
    check_val("ooo_idle", pc_obs(), pc(1'b0, 0));
    check_val("ooo_empty", 32'(empty_o), 32'd1);

    // No-destination entries and a stray branch result
    do_reset();
    br_res(1'b0);
    check_val("stray_br_full", 32'(rob_full_o), 32'd0);
    disp(1'b0, 1'b1, 0);
    disp(1'b0, 1'b0, 9);
    check_val("nodst_notempty", 32'(empty_o), 32'd0);
    wb(0);
    wb(1);
    check_val("nodst_pc0", pc_obs(), pc(1'b0, 0));
    step();
    check_val("nodst_pc1", pc_obs(), pc(1'b0, 0));
    check_val("nodst_empty", 32'(empty_o), 32'd1);

    // Mispredict
    do_reset();
    disp_branch_set();
    check_val("mp_tag_pre", 32'(rob_tag_o), 32'd7);
    br_res(1'b0);
    check_val("mp_full0", 32'(rob_full_o), 32'd1);
    check_val("mp_pc0", pc_obs(), pc(1'b0, 0));
    step();
    check_val("mp_full1", 32'(rob_full_o), 32'd1);
    check_val("mp_pc52", pc_obs(), pc(1'b1, 52));
    step();
    check_val("mp_full2", 32'(rob_full_o), 32'd1);
    check_val("mp_pc_none", pc_obs(), pc(1'b0, 0));
    step();
    check_val("mp_full3", 32'(rob_full_o), 32'd0);
    check_val("mp_pc50", pc_obs(), pc(1'b1, 50));
    check_val("mp_tail", 32'(rob_tag_o), 32'd4);
    wb(0); wb(1); wb(2); wb(3);
    check_val("mp_pc12", pc_obs(), pc(1'b1, 12));
    step();
    check_val("mp_br_commit", pc_obs(), pc(1'b0, 0));
    check_val("mp_empty", 32'(empty_o), 32'd1);

    // Correct prediction
    do_reset();
    disp_branch_set();
    br_res(1'b1);
    check_val("hit_full", 32'(rob_full_o), 32'd0);
    check_val("hit_tag", 32'(rob_tag_o), 32'd7);
    for (int k = 0; k < 7; k++) begin
      wb(k);
      if (k >= 1) check_val("hit_pc", pc_obs(), pc(hit_v[k-1], hit_i[k-1]));
    end
    step();
    check_val("hit_pc_last", pc_obs(), pc(hit_v[6], hit_i[6]));
    check_val("hit_empty", 32'(empty_o), 32'd1);

    // Reset during the second flush cycle
    do_reset();
    disp_branch_set();
    br_res(1'b0);
    step();
    check_val("rf_pc52", pc_obs(), pc(1'b1, 52));
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check_val("rf_empty", 32'(empty_o), 32'd1);
    check_val("rf_full", 32'(rob_full_o), 32'd0);
    check_val("rf_pc", pc_obs(), pc(1'b0, 0));
    check_val("rf_tag", 32'(rob_tag_o), 32'd0);
    for (int m = 0; m < 3; m++) begin
      step();
      check_val("rf_quiet", pc_obs(), pc(1'b0, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
